// File: rtl/pim_array_controller.sv
// pim_array_controller: host bus to NUM_PIM PIM cores, each with a private 1-port RAM.
// Per-channel IDLE/RUN/DONE FSM decides RAM ownership and core reset; host polls STATUS or takes irq.
module pim_array_controller #(
    parameter int          NUM_PIM   = 2,
    parameter int          RAM_AW    = 10,
    parameter logic [7:0]  BASE_HI   = 8'h20,
    parameter logic [31:0] DONE_ADDR = 32'h0000_1000
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [31:0]                host_addr,
    input  logic [31:0]                host_wdata,
    input  logic [3:0]                 host_wmask,
    input  logic                       host_rstrb,
    output logic [31:0]                host_rdata,
    output logic                       host_hit_q,
    output logic                       host_rbusy,
    output logic                       host_wbusy,
    output logic                       irq,
    output logic [NUM_PIM-1:0]         pim_rstN,
    input  logic [NUM_PIM*32-1:0]      pim_addr,
    input  logic [NUM_PIM*32-1:0]      pim_wdata,
    input  logic [NUM_PIM*4-1:0]       pim_wmask,
    input  logic [NUM_PIM-1:0]         pim_rstrb,
    output logic [NUM_PIM*32-1:0]      pim_rdata,
    output logic [NUM_PIM-1:0]         pim_rbusy,
    output logic [NUM_PIM-1:0]         pim_wbusy,
    output logic [NUM_PIM*RAM_AW-1:0]  ram_addr,
    output logic [NUM_PIM*32-1:0]      ram_wdata,
    output logic [NUM_PIM*4-1:0]       ram_byteena,
    output logic [NUM_PIM-1:0]         ram_wen,
    output logic [NUM_PIM-1:0]         ram_rden,
    input  logic [NUM_PIM*32-1:0]      ram_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state [NUM_PIM];
    state_t             w_state_nxt [NUM_PIM];
    logic [NUM_PIM-1:0] r_done, r_err, r_irq_en, r_pim_rstn, r_irq;
    logic [NUM_PIM-1:0] w_done_nxt, w_err_nxt, w_irq_en_nxt;
    logic [NUM_PIM-1:0] w_run, w_done_st, w_host_sel, w_err_set;
    logic               r_rd_vld, r_rd_ram, r_rd_busy;
    logic [2:0]         r_rd_ch;
    logic [31:0]        r_ctrl_q, w_ram_q, w_status, w_ctrl_rd;
    logic               w_hit, w_ctrl, w_wr, w_start, w_halt, w_clear, w_irqen_wr, w_unused;
    logic [3:0]         w_ch;
    logic [11:0]        w_off;

    assign w_hit      = host_addr[31:24] == BASE_HI;
    assign w_ch       = host_addr[15:12];
    assign w_off      = host_addr[11:0];
    assign w_ctrl     = w_hit && w_ch == 4'hF;
    assign w_wr       = |host_wmask;
    assign w_start    = w_ctrl && w_wr && w_off == 12'h000;
    assign w_halt     = w_ctrl && w_wr && w_off == 12'h004;
    assign w_clear    = w_ctrl && w_wr && w_off == 12'h008;
    assign w_irqen_wr = w_ctrl && w_wr && w_off == 12'h00C;
    assign w_unused   = ^host_addr[23:16];

    for (genvar i = 0; i < NUM_PIM; i++) begin : g_ch
        logic [31:0] w_pa;
        logic [3:0]  w_pwm;
        assign w_pa          = pim_addr[i*32 +: 32];
        assign w_pwm         = pim_wmask[i*4 +: 4];
        assign w_run[i]      = r_state[i] == S_RUN;
        assign w_done_st[i]  = w_run[i] && |w_pwm && w_pa == DONE_ADDR;
        assign w_host_sel[i] = w_hit && w_ch == 4'(i);
        assign w_err_set[i]  = w_host_sel[i] && w_run[i] && (w_wr || host_rstrb);
        // Ownership follows the current state, so the mux flips on the same edge as the FSM.
        assign ram_addr[i*RAM_AW +: RAM_AW] = w_run[i] ? w_pa[RAM_AW+1:2] : host_addr[RAM_AW+1:2];
        assign ram_wdata[i*32 +: 32]        = w_run[i] ? pim_wdata[i*32 +: 32] : host_wdata;
        assign ram_byteena[i*4 +: 4]        = w_run[i] ? w_pwm : host_wmask;
        assign ram_wen[i]  = w_run[i] ? (|w_pwm && w_pa != DONE_ADDR) : (w_host_sel[i] && w_wr);
        assign ram_rden[i] = w_run[i] ? pim_rstrb[i] : (w_host_sel[i] && host_rstrb);
        assign pim_rdata[i*32 +: 32] = ram_rdata[i*32 +: 32];
    end

    always_comb begin
        for (int i = 0; i < NUM_PIM; i++) begin
            w_state_nxt[i] = r_state[i];
            w_done_nxt[i]  = r_done[i];
            w_err_nxt[i]   = r_err[i] | w_err_set[i];
            if (w_clear && host_wdata[i]) begin
                w_done_nxt[i]  = 1'b0;
                w_err_nxt[i]   = 1'b0;
                w_state_nxt[i] = r_state[i] == S_DONE ? S_IDLE : r_state[i];
            end
            if (w_start && host_wdata[i] && r_state[i] != S_RUN) begin
                w_state_nxt[i] = S_RUN;
                w_done_nxt[i]  = 1'b0;
            end
            if (w_done_st[i]) begin
                w_state_nxt[i] = S_DONE;
                w_done_nxt[i]  = 1'b1;
            end
            // HALT overrides a completion store landing in the same cycle.
            if (w_halt && host_wdata[i]) begin
                w_state_nxt[i] = S_IDLE;
                w_done_nxt[i]  = r_done[i];
            end
        end
    end

    assign w_irq_en_nxt = w_irqen_wr ? host_wdata[NUM_PIM-1:0] : r_irq_en;
    assign w_status     = {8'h00, 8'(r_err), 8'(r_done), 8'(w_run)};
    assign w_ctrl_rd    = w_off == 12'h00C ? 32'(r_irq_en) : w_off == 12'h010 ? w_status : 32'h0;

    always_comb begin
        w_ram_q = 32'h0;
        for (int i = 0; i < NUM_PIM; i++)
            if (r_rd_ch == 3'(i)) w_ram_q = ram_rdata[i*32 +: 32];
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_PIM; i++) r_state[i] <= S_IDLE;
            r_done     <= '0;
            r_err      <= '0;
            r_irq_en   <= '0;
            r_pim_rstn <= '0;
            r_irq      <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_ram   <= 1'b0;
            r_rd_busy  <= 1'b0;
            r_rd_ch    <= '0;
            r_ctrl_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_PIM; i++) begin
                r_state[i]    <= w_state_nxt[i];
                r_pim_rstn[i] <= w_state_nxt[i] == S_RUN;
            end
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_irq_en  <= w_irq_en_nxt;
            r_irq     <= {{(NUM_PIM-1){1'b0}}, |(w_done_nxt & w_irq_en_nxt)};
            r_rd_vld  <= w_hit && host_rstrb;
            r_rd_ram  <= 32'(w_ch) < NUM_PIM;
            r_rd_busy <= |(w_host_sel & w_run);
            r_rd_ch   <= w_ch[2:0];
            r_ctrl_q  <= w_ctrl ? w_ctrl_rd : 32'h0;
        end
    end

    assign host_rdata = !r_rd_vld ? 32'h0 : r_rd_ram ? (r_rd_busy ? 32'hDEAD_BEEF : w_ram_q) : r_ctrl_q;
    assign host_hit_q = r_rd_vld;
    assign irq        = r_irq[0];
    assign pim_rstN   = r_pim_rstn;
    assign host_rbusy = 1'b0;
    assign host_wbusy = 1'b0;
    assign pim_rbusy  = '0;
    assign pim_wbusy  = '0;
endmodule
